// File: rtl/i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_pkg                                                |
// | Description : Shared constants, bit-index type and channel helper    |
// |               for the I2S sine transmitter.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int CHAN_BITS  = 16;

  // Position of the current bclk period inside a 32-bit frame.
  typedef logic [4:0] bit_idx_t;

  localparam bit_idx_t BIT_IDX_LAST = bit_idx_t'(FRAME_BITS - 1);

  // Word-select value for a frame position: left half 0, right half 1.
  function automatic logic channel_of(input bit_idx_t idx);
    return (idx >= bit_idx_t'(CHAN_BITS));
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_sine_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_sine_tx_if                                         |
// | Description : Valid/ready sample handshake between the sine          |
// |               generator (master) and the I2S transmitter (slave).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface i2s_sine_tx_if;
  import i2s_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_bclk_gen                                           |
// | Description : Divides clk down to the I2S bit clock and flags the    |
// |               clk cycle in which bclk is about to rise or fall.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  wire  clk,
  input  wire  reset,
  output logic bclk,
  output logic rise_stb,
  output logic fall_stb
);
  import i2s_pkg::*;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             bclk_q;
  logic             bclk_d;
  logic             term;

  // Strobes are combinational so that the consumer updates on the very
  // edge at which bclk itself changes.
  assign term      = (div_cnt_q == C_DIV_LAST);
  assign div_cnt_d = term ? '0 : div_cnt_q + DIV_W'(1);
  assign bclk_d    = term ? ~bclk_q : bclk_q;
  assign rise_stb  = term & ~bclk_q;
  assign fall_stb  = term &  bclk_q;
  assign bclk      = bclk_q;

  // Divider counter and bit-clock toggle register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_sine_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2s_sine_tx                                            |
// | Description : Philips I2S serialiser. One-entry input buffer, the    |
// |               same sample on both channels, underrun/overflow        |
// |               pulses.                                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2s_sine_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = i2s_pkg::SAMPLE_W
) (
  input  wire         clk,
  input  wire         reset,
  i2s_sine_tx_if.slave smp,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        underrun,
  output logic        overflow
);

  localparam int SHIFT_W = 2 * SAMPLE_W;

  logic                 rise_stb;
  logic                 fall_stb;
  logic                 load;
  logic                 xfer;

  i2s_pkg::bit_idx_t    bit_idx_q, bit_idx_d;
  logic                 lrck_q, lrck_d;
  logic                 sdata_q, sdata_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [SAMPLE_W-1:0]  hold_q, hold_d;
  logic [SAMPLE_W-1:0]  last_q, last_d;
  logic                 full_q, full_d;
  logic                 ready_q, ready_d;
  logic                 underrun_q, underrun_d;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Frame load happens on the fall strobe that wraps bit_idx to 0.
  assign load = fall_stb & (bit_idx_q == i2s_pkg::BIT_IDX_LAST);
  // ready is registered, so a sample offered in the load cycle is refused.
  assign xfer = smp.sample_valid & ready_q;

  // Next-state: frame position, serial shift, buffer and underrun flag.
  always_comb begin
    bit_idx_d  = bit_idx_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    last_d     = last_q;
    full_d     = full_q;
    underrun_d = 1'b0;

    if (fall_stb) begin
      bit_idx_d = bit_idx_q + i2s_pkg::bit_idx_t'(1);
      lrck_d    = i2s_pkg::channel_of(bit_idx_d);
      // One-bit delay stage: this gives the I2S one-bclk lag behind lrck.
      sdata_d   = shift_q[SHIFT_W-1];
      shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
    end

    if (load) begin
      if (full_q) begin
        shift_d = {hold_q, hold_q};
        last_d  = hold_q;
        full_d  = 1'b0;
      end else begin
        shift_d    = {last_q, last_q};
        underrun_d = 1'b1;
      end
    end

    if (xfer) begin
      hold_d = smp.sample_in;
      full_d = 1'b1;
    end
  end

  assign ready_d = ~full_d;

  // State registers with asynchronous reset to the idle frame position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx_q  <= i2s_pkg::BIT_IDX_LAST;
      lrck_q     <= 1'b1;
      sdata_q    <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      last_q     <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign smp.sample_ready = ready_q;
  assign lrck             = lrck_q;
  assign sdata            = sdata_q;
  assign underrun         = underrun_q;
  // Flags the dropped sample in the very cycle it is offered.
  assign overflow         = smp.sample_valid & ~ready_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sine_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_i2s_sine_tx                                         |
// | Description : Self-checking bench for i2s_sine_tx against a          |
// |               time-based frame model.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_i2s_sine_tx;

  localparam int CD = 2;

  logic clk = 1'b0;
  logic reset;
  logic bclk, lrck, sdata, underrun, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_sine_tx_if u_if ();

  i2s_sine_tx #(
    .CLK_DIV (CD)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .smp      (u_if),
    .bclk     (bclk),
    .lrck     (lrck),
    .sdata    (sdata),
    .underrun (underrun),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: everything derives from the clk-edge count since reset.
  int          m_t;
  logic        m_full;
  logic [15:0] m_hold;
  logic [15:0] m_cur;
  logic [15:0] m_prev;
  logic        m_uf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, req, $time);
    end
  endtask

  function automatic int exp_bidx(input int t);
    return (31 + t / (2 * CD)) % 32;
  endfunction

  function automatic logic exp_sdata(input int b);
    if (b == 0)       return m_prev[0];
    else if (b <= 16) return m_cur[16 - b];
    else              return m_cur[32 - b];
  endfunction

  task automatic model_reset();
    m_t    = 0;
    m_full = 1'b0;
    m_hold = '0;
    m_cur  = '0;
    m_prev = '0;
    m_uf   = 1'b0;
  endtask

  // One clk cycle; entered and left at a negedge.
  task automatic step(input logic v, input logic [15:0] d);
    int  b;
    logic pre_full;
    logic ld;
    b = exp_bidx(m_t);
    check_eq("bclk",     {31'd0, bclk},                  {31'd0, logic'((m_t / CD) % 2)});
    check_eq("lrck",     {31'd0, lrck},                  {31'd0, logic'(b >= 16)});
    check_eq("sdata",    {31'd0, sdata},                 {31'd0, exp_sdata(b)});
    check_eq("ready",    {31'd0, u_if.sample_ready},     {31'd0, ~m_full});
    check_eq("underrun", {31'd0, underrun},              {31'd0, m_uf});
    u_if.sample_valid = v;
    u_if.sample_in    = d;
    #1;
    check_eq("overflow", {31'd0, overflow},              {31'd0, v & m_full});
    @(posedge clk);
    pre_full = m_full;
    m_t++;
    ld   = ((m_t % (2 * CD)) == 0) && (((m_t / (2 * CD)) % 32) == 1);
    m_uf = 1'b0;
    if (ld) begin
      m_prev = m_cur;
      if (pre_full) m_cur = m_hold;
      else          m_uf  = 1'b1;
      m_full = 1'b0;
    end
    if (v && !pre_full) begin
      m_hold = d;
      m_full = 1'b1;
    end
    @(negedge clk);
    u_if.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && m_full; i++) step(1'b0, 16'h0);
    check_eq("wait_ready", {31'd0, u_if.sample_ready}, 32'd1);
  endtask

  // Asserts reset away from any clk edge and checks the immediate values.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_bclk",     {31'd0, bclk},              32'd0);
    check_eq("rst_lrck",     {31'd0, lrck},              32'd1);
    check_eq("rst_sdata",    {31'd0, sdata},             32'd0);
    check_eq("rst_ready",    {31'd0, u_if.sample_ready}, 32'd1);
    check_eq("rst_underrun", {31'd0, underrun},          32'd0);
    check_eq("rst_overflow", {31'd0, overflow},          32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stream [3];
    stream[0] = 16'h7FFF;
    stream[1] = 16'hC000;
    stream[2] = 16'h0000;
    u_if.sample_valid = 1'b0;
    u_if.sample_in    = 16'h0;
    reset             = 1'b1;
    #3;

    // Idle after reset: underrun each frame, sdata low.
    apply_reset();
    idle(300);

    // Single sample accepted at clk 10.
    apply_reset();
    idle(9);
    step(1'b1, 16'h8001);
    idle(400);

    // Stream, one sample per frame.
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      step(1'b1, stream[i]);
    end
    idle(300);

    // Back-to-back: second one dropped with an overflow pulse.
    wait_ready();
    step(1'b1, 16'h1111);
    step(1'b1, 16'h2222);
    idle(200);

    // Underrun repeat of the last sample.
    wait_ready();
    step(1'b1, 16'h1234);
    idle(520);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, 16'($urandom));

    // Mid-frame reset at bit_idx 20 with the buffer full.
    wait_ready();
    step(1'b1, 16'hABCD);
    for (int i = 0; i < 300 && exp_bidx(m_t) != 20; i++) step(1'b0, 16'h0);
    check_eq("reach_bidx20", exp_bidx(m_t), 20);
    #2;
    apply_reset();
    idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
